// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: controller state
// encodings and the borrow / signed-overflow helpers.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Borrow out of a single full-subtractor cell computing x - y - bin.
   function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
      return (~x & y) | (~(x ^ y) & bin);
   endfunction

   // Signed overflow of a - b from the operand and result sign bits.
   function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
      return (a_msb != b_msb) && (d_msb != a_msb);
   endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor
   import serial_subtractor_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = fs_borrow(x, y, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
// LSB first, with a start/done handshake and results held between operations.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             ovf
);

   localparam int unsigned          CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

   state_e             state_q;
   logic [WIDTH-1:0]   a_sr_q;
   logic [WIDTH-1:0]   b_sr_q;
   logic [WIDTH-2:0]   res_sr_q;
   logic               brw_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               a_msb_q;
   logic               b_msb_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   diff_q;
   logic               borrow_q;
   logic               ovf_q;

   logic               d_bit;
   logic               brw_d;
   logic [WIDTH-1:0]   res_d;

   full_subtractor u_fs (
      .x    (a_sr_q[0]),
      .y    (b_sr_q[0]),
      .bin  (brw_q),
      .d    (d_bit),
      .bout (brw_d)
   );

   // Partial result with the current bit shifted in at the MSB; on the last
   // bit this is the complete difference.
   assign res_d = {d_bit, res_sr_q};

   // Controller, operand/result shift registers and held result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_sr_q <= '0;
         brw_q    <= 1'b0;
         cnt_q    <= '0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  a_sr_q  <= a;
                  b_sr_q  <= b;
                  a_msb_q <= a[WIDTH-1];
                  b_msb_q <= b[WIDTH-1];
                  brw_q   <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_SHIFT;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               a_sr_q   <= a_sr_q >> 1;
               b_sr_q   <= b_sr_q >> 1;
               res_sr_q <= res_d[WIDTH-1:1];
               brw_q    <= brw_d;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  diff_q   <= res_d;
                  borrow_q <= brw_d;
                  ovf_q    <= sub_ovf(a_msb_q, b_msb_q, d_bit);
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= ST_DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and small random bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         ovf;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] held_diff;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One operation with start pulsed for a single cycle; a stray start with
   // garbage operands is injected mid-SHIFT and must be ignored.
   task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb, input logic eo);
      int n;
      a = av;
      b = bv;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = ~av;
      b = bv ^ 8'h5A;
      check({tag, "/busy"}, 32'(busy), 32'd1);
      check({tag, "/hold"}, 32'(diff), 32'(held_diff));
      n = 0;
      while (!done && n < 20) begin
         start = (n == 3);
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      check({tag, "/latency"}, 32'(n), 32'd8);
      check({tag, "/diff"},    32'(diff), 32'(ed));
      check({tag, "/borrow"},  32'(borrow_out), 32'(eb));
      check({tag, "/ovf"},     32'(ovf), 32'(eo));
      held_diff = ed;
      @(posedge clk); #1;
      check({tag, "/done_pulse"}, 32'(done), 32'd0);
      check({tag, "/idle"},       32'(busy), 32'd0);
      check({tag, "/held"},       32'(diff), 32'(ed));
   endtask

   initial begin
      int n;
      int pulses;
      logic [W-1:0] ra, rb, rd;

      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      held_diff = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst/busy",   32'(busy), 32'd0);
      check("rst/done",   32'(done), 32'd0);
      check("rst/diff",   32'(diff), 32'd0);
      check("rst/borrow", 32'(borrow_out), 32'd0);
      check("rst/ovf",    32'(ovf), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("t1_35m12", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
      run_op("t2_12m35", 8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
      run_op("t3_80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      run_op("t3_7Fm_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
      run_op("x_00m01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
      run_op("x_80m80", 8'h80, 8'h80, 8'h00, 1'b0, 1'b0);

      // Start held high: back-to-back operations every 9 cycles, operand
      // changes mid-SHIFT have no effect.
      a = 8'h05; b = 8'h03; start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         do begin
            @(posedge clk); #1;
            n++;
            if (n == 4) begin a = 8'hAA; b = 8'h11; end
            if (n == 7) begin a = 8'h05; b = 8'h03; end
         end while (!done && n < 20);
         check("t4/period", 32'(n), 32'd9);
         check("t4/diff",   32'(diff), 32'h02);
         check("t4/borrow", 32'(borrow_out), 32'd0);
      end
      start = 1'b0;
      @(posedge clk); #1;
      check("t4/stop", 32'(busy), 32'd0);
      held_diff = 8'h02;

      // Reset 4 cycles into SHIFT aborts the operation.
      a = 8'h35; b = 8'h12; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t5/busy", 32'(busy), 32'd0);
      check("t5/diff", 32'(diff), 32'd0);
      held_diff = '0;
      pulses = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check("t5/no_done", 32'(pulses), 32'd0);
      run_op("t5_FFmFF", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

      // Reset wins over start at the same edge.
      a = 8'h44; b = 8'h01; start = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; rst = 1'b0;
      check("rst_vs_start/busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("rst_vs_start/idle", 32'(busy), 32'd0);

      // Random operands against the arithmetic reference.
      for (int k = 0; k < 150; k++) begin
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         rd = ra - rb;
         run_op("rand", ra, rb, rd, (ra < rb), (ra[W-1] != rb[W-1]) && (rd[W-1] != ra[W-1]));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
